// File: rtl/idu_stage.sv
// idu_stage: instruction-decode stage of the NPC core.
// Holds one {pc, instr} pair from fetch in a stage register behind a valid/ready
// handshake and presents the RV32I decode of the held word to execute.
// A branch-redirect flush squashes the held and the same-cycle incoming instruction.
// Optional feature macro: IDU_PERF_EN adds perf_decoded/perf_stall/perf_bubble counters.
module idu_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
`ifdef IDU_PERF_EN
  ,
  parameter int PERF_W = 32
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic        funct7_b5,
  output logic [31:0] imm,
  output logic [3:0]  op_class,
  output logic        rd_wen,
  output logic        illegal
`ifdef IDU_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_decoded,
  output logic [PERF_W-1:0] perf_stall,
  output logic [PERF_W-1:0] perf_bubble
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  typedef enum logic [3:0] {
    OC_LUI     = 4'd0,
    OC_AUIPC   = 4'd1,
    OC_JAL     = 4'd2,
    OC_JALR    = 4'd3,
    OC_BRANCH  = 4'd4,
    OC_LOAD    = 4'd5,
    OC_STORE   = 4'd6,
    OC_OP_IMM  = 4'd7,
    OC_OP      = 4'd8,
    OC_SYSTEM  = 4'd9,
    OC_ILLEGAL = 4'd15
  } op_class_e;

  // Full 7-bit major opcodes; any word whose low two bits are not 2'b11 matches none.
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        accept;
  logic        fire;

  // Handshake: stage accepts when empty, when the held bundle leaves, or on flush; never in reset.
  always_comb begin
    in_ready = !rst && (flush || (state_q == EMPTY) || out_ready);
    accept   = in_valid && in_ready;
    fire     = (state_q == FULL) && out_ready;
  end

  // Next state: flush wins and keeps the payload untouched; otherwise load on accept, drain on fire.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (flush) begin
      state_d = EMPTY;
    end else if (accept) begin
      state_d = FULL;
      pc_d    = in_pc;
      instr_d = in_instr;
    end else if (fire) begin
      state_d = EMPTY;
    end
  end

  // Stage register with synchronous reset to an empty stage holding a NOP.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: payload registers are reset too, so the decode outputs read as a NOP out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_pc    = pc_q;
  assign out_instr = instr_q;
  assign rs1       = instr_q[19:15];
  assign rs2       = instr_q[24:20];
  assign rd        = instr_q[11:7];
  assign funct3    = instr_q[14:12];
  assign funct7_b5 = instr_q[30];

  op_class_e   cls;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  // Decode the registered word: op class, format-specific sign-extended immediate, write enable.
  always_comb begin
    imm_i = {{20{instr_q[31]}}, instr_q[31:20]};
    imm_s = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
    imm_b = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
    imm_u = {instr_q[31:12], 12'b0};
    imm_j = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};

    cls = OC_ILLEGAL;
    unique case (instr_q[6:0])
      OPC_LUI:    cls = OC_LUI;
      OPC_AUIPC:  cls = OC_AUIPC;
      OPC_JAL:    cls = OC_JAL;
      OPC_JALR:   cls = OC_JALR;
      OPC_BRANCH: cls = OC_BRANCH;
      OPC_LOAD:   cls = OC_LOAD;
      OPC_STORE:  cls = OC_STORE;
      OPC_OP_IMM: cls = OC_OP_IMM;
      OPC_OP:     cls = OC_OP;
      OPC_SYSTEM: cls = OC_SYSTEM;
      default:    cls = OC_ILLEGAL;
    endcase

    imm = '0;
    unique case (cls)
      OC_LUI, OC_AUIPC:                      imm = imm_u;
      OC_JAL:                                imm = imm_j;
      OC_JALR, OC_LOAD, OC_OP_IMM, OC_SYSTEM: imm = imm_i;
      OC_BRANCH:                             imm = imm_b;
      OC_STORE:                              imm = imm_s;
      default:                               imm = '0;
    endcase

    op_class = cls;
    illegal  = (cls == OC_ILLEGAL);
    rd_wen   = !((cls == OC_BRANCH) || (cls == OC_STORE) || (cls == OC_ILLEGAL))
               && (instr_q[11:7] != 5'd0);
  end

`ifdef IDU_PERF_EN
  logic [PERF_W-1:0] perf_decoded_q, perf_decoded_d;
  logic [PERF_W-1:0] perf_stall_q, perf_stall_d;
  logic [PERF_W-1:0] perf_bubble_q, perf_bubble_d;

  // Event counters: bundles consumed, back-pressured cycles, empty cycles; wrap naturally.
  always_comb begin
    perf_decoded_d = perf_decoded_q + PERF_W'(fire);
    perf_stall_d   = perf_stall_q + PERF_W'((state_q == FULL) && !out_ready);
    perf_bubble_d  = perf_bubble_q + PERF_W'(state_q == EMPTY);
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_decoded_q <= '0;
      perf_stall_q   <= '0;
      perf_bubble_q  <= '0;
    end else begin
      perf_decoded_q <= perf_decoded_d;
      perf_stall_q   <= perf_stall_d;
      perf_bubble_q  <= perf_bubble_d;
    end
  end

  assign perf_decoded = perf_decoded_q;
  assign perf_stall   = perf_stall_q;
  assign perf_bubble  = perf_bubble_q;
`endif

endmodule

// File: tb/tb_idu_stage.sv
// tb_idu_stage: self-checking bench for idu_stage with a transaction-level
// reference model (one-entry holding slot + RV32I decode by arithmetic).
module tb_idu_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;
  logic        funct7_b5;
  logic [31:0] imm;
  logic [3:0]  op_class;
  logic        rd_wen;
  logic        illegal;
`ifdef IDU_PERF_EN
  logic [31:0] perf_decoded, perf_stall, perf_bubble;
`endif

  idu_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .funct3    (funct3),
    .funct7_b5 (funct7_b5),
    .imm       (imm),
    .op_class  (op_class),
    .rd_wen    (rd_wen),
    .illegal   (illegal)
`ifdef IDU_PERF_EN
    ,
    .perf_decoded (perf_decoded),
    .perf_stall   (perf_stall),
    .perf_bubble  (perf_bubble)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state: the one slot between fetch and execute.
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  int unsigned m_dec, m_stall, m_bub;

  typedef struct packed {
    logic [3:0]  cls;
    logic [31:0] imm;
    logic        rd_wen;
    logic        illegal;
  } dec_t;

  // RV32I decode from the ISA rules, immediates built by signed arithmetic.
  function automatic dec_t ref_decode(input logic [31:0] ins);
    dec_t d;
    int   v;
    d.cls = 4'd15;
    if (ins[1:0] == 2'b11) begin
      case (ins[6:2])
        5'b01101: d.cls = 4'd0;
        5'b00101: d.cls = 4'd1;
        5'b11011: d.cls = 4'd2;
        5'b11001: d.cls = 4'd3;
        5'b11000: d.cls = 4'd4;
        5'b00000: d.cls = 4'd5;
        5'b01000: d.cls = 4'd6;
        5'b00100: d.cls = 4'd7;
        5'b01100: d.cls = 4'd8;
        5'b11100: d.cls = 4'd9;
        default:  d.cls = 4'd15;
      endcase
    end
    case (d.cls)
      4'd0, 4'd1: v = int'(ins[31:12]) * 4096;
      4'd2: v = int'(ins[30:21]) * 2 + int'(ins[20]) * 2048 + int'(ins[19:12]) * 4096
               - int'(ins[31]) * 1048576;
      4'd3, 4'd5, 4'd7, 4'd9: v = int'(ins[30:20]) - int'(ins[31]) * 2048;
      4'd4: v = int'(ins[11:8]) * 2 + int'(ins[30:25]) * 32 + int'(ins[7]) * 2048
               - int'(ins[31]) * 4096;
      4'd6: v = int'(ins[11:7]) + int'(ins[30:25]) * 32 - int'(ins[31]) * 2048;
      default: v = 0;
    endcase
    d.imm     = 32'(v);
    d.illegal = (d.cls == 4'd15);
    d.rd_wen  = !(d.cls == 4'd4 || d.cls == 4'd6 || d.cls == 4'd15) && (ins[11:7] != 5'd0);
    return d;
  endfunction

  // Apply one cycle of inputs, advance the model across the edge, return 1ns after the edge.
  task automatic drive_cycle(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                             input logic fl, input logic ordy);
    logic rdy, acc, fire;
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    flush     = fl;
    out_ready = ordy;
    #1;
    rdy  = !m_valid || ordy || fl;
    acc  = v && rdy;
    fire = m_valid && ordy;
    if (fire) m_dec++;
    if (m_valid && !ordy) m_stall++;
    if (!m_valid) m_bub++;
    if (fl) m_valid = 1'b0;
    else if (acc) begin
      m_valid = 1'b1;
      m_pc    = pc;
      m_instr = ins;
    end else if (fire) m_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_valid = 1'b0; m_pc = '0; m_instr = 32'h00000013;
    m_dec = 0; m_stall = 0; m_bub = 0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++;
    if (out_instr !== 32'h00000013) begin failures++; $display("FAIL reset_out_instr got=%h exp=00000013", out_instr); end
    checks++;
    if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
    checks++;
    if ({op_class, imm, rd, rd_wen, illegal} !== {4'd7, 32'h0, 5'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_decode got cls=%0d imm=%h rd=%0d wen=%b ill=%b exp cls=7 imm=0 rd=0 wen=0 ill=0",
               op_class, imm, rd, rd_wen, illegal);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    @(posedge clk);
    #1;
    m_bub++;
  endtask

  task automatic test_basic;
    drive_cycle(1'b1, 32'h80000000, 32'h00500093, 1'b0, 1'b1);
    checks++;
    if ({out_valid, out_pc, op_class, rd, rs1, imm, rd_wen} !==
        {1'b1, 32'h80000000, 4'd7, 5'd1, 5'd0, 32'd5, 1'b1}) begin
      failures++;
      $display("FAIL basic_addi got v=%b pc=%h cls=%0d rd=%0d rs1=%0d imm=%h wen=%b exp v=1 pc=80000000 cls=7 rd=1 rs1=0 imm=5 wen=1",
               out_valid, out_pc, op_class, rd, rs1, imm, rd_wen);
    end
  endtask

  task automatic test_stall;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 32'h80000004, 32'h00A00113, 1'b0, 1'b0);
      checks++;
      if ({in_ready, out_valid, out_pc, out_instr, imm} !==
          {1'b0, 1'b1, 32'h80000000, 32'h00500093, 32'd5}) begin
        failures++;
        $display("FAIL stall_hold[%0d] got rdy=%b v=%b pc=%h instr=%h imm=%h exp rdy=0 v=1 pc=80000000 instr=00500093 imm=5",
                 i, in_ready, out_valid, out_pc, out_instr, imm);
      end
    end
    drive_cycle(1'b1, 32'h80000004, 32'h00A00113, 1'b0, 1'b1);
    checks++;
    if ({out_valid, out_pc, out_instr, imm, rd} !== {1'b1, 32'h80000004, 32'h00A00113, 32'd10, 5'd2}) begin
      failures++;
      $display("FAIL stall_release got v=%b pc=%h instr=%h imm=%h rd=%0d exp v=1 pc=80000004 instr=00a00113 imm=a rd=2",
               out_valid, out_pc, out_instr, imm, rd);
    end
  endtask

  task automatic test_flush;
    drive_cycle(1'b1, 32'h80000008, 32'h00500093, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_squash got v=%b exp 0", out_valid); end
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_replay got v=%b exp 0", out_valid); end
  endtask

  task automatic test_decode;
    logic [31:0] words [6];
    dec_t e;
    words = '{32'hFE208EE3, 32'hFFFFFFFF, 32'h123450B7, 32'h0080006F, 32'hFE112E23, 32'h00100073};
    drive_cycle(1'b1, 32'h100, words[0], 1'b0, 1'b1);
    checks++;
    if ({op_class, imm, rd_wen} !== {4'd4, 32'hFFFFFFFC, 1'b0}) begin
      failures++;
      $display("FAIL decode_beq got cls=%0d imm=%h wen=%b exp cls=4 imm=fffffffc wen=0", op_class, imm, rd_wen);
    end
    drive_cycle(1'b1, 32'h104, words[1], 1'b0, 1'b1);
    checks++;
    if ({illegal, op_class, imm, rd_wen} !== {1'b1, 4'd15, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL decode_illegal got ill=%b cls=%0d imm=%h wen=%b exp ill=1 cls=15 imm=0 wen=0",
               illegal, op_class, imm, rd_wen);
    end
    for (int i = 2; i < 6; i++) begin
      drive_cycle(1'b1, 32'h100 + 32'(4 * i), words[i], 1'b0, 1'b1);
      e = ref_decode(words[i]);
      checks++;
      if ({op_class, imm, rd_wen, illegal} !== e) begin
        failures++;
        $display("FAIL decode_word %h got cls=%0d imm=%h wen=%b ill=%b exp cls=%0d imm=%h wen=%b ill=%b",
                 words[i], op_class, imm, rd_wen, illegal, e.cls, e.imm, e.rd_wen, e.illegal);
      end
    end
  endtask

  task automatic test_random;
    logic [6:0] opcodes [10];
    logic [31:0] ins;
    dec_t e;
    logic [118:0] got, exp;
    int errs_before;
    opcodes = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
    errs_before = failures;
    for (int i = 0; i < 400; i++) begin
      ins = $urandom;
      if ($urandom_range(0, 5) != 0) ins[6:0] = opcodes[$urandom_range(0, 9)];
      drive_cycle(1'($urandom_range(0, 3) != 0), $urandom, ins,
                  1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 2) != 0));
      e = ref_decode(m_instr);
      got = {out_valid, out_pc, out_instr, rs1, rs2, rd, funct3, funct7_b5, op_class, imm, rd_wen, illegal, in_ready};
      exp = {m_valid, m_pc, m_instr, m_instr[19:15], m_instr[24:20], m_instr[11:7], m_instr[14:12], m_instr[30],
             e.cls, e.imm, e.rd_wen, e.illegal, !m_valid || out_ready || flush};
      checks++;
      if (got !== exp) begin
        failures++;
        if (failures - errs_before <= 10)
          $display("FAIL random_cycle[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

`ifdef IDU_PERF_EN
  task automatic test_perf;
    test_reset();
    drive_cycle(1'b1, 32'h200, 32'h00100093, 1'b0, 1'b1);
    drive_cycle(1'b1, 32'h204, 32'h00200113, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h204, 32'h00200113, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h204, 32'h00200113, 1'b0, 1'b1);
    drive_cycle(1'b1, 32'h208, 32'h00300193, 1'b0, 1'b1);
    drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    repeat (4) drive_cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    checks++;
    if ({perf_decoded, perf_stall} !== {32'd3, 32'd2}) begin
      failures++;
      $display("FAIL perf_dec_stall got dec=%0d stall=%0d exp dec=3 stall=2", perf_decoded, perf_stall);
    end
    checks++;
    if (perf_bubble !== 32'(m_bub)) begin
      failures++;
      $display("FAIL perf_bubble got=%0d exp=%0d", perf_bubble, m_bub);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0; flush = 1'b0; out_ready = 1'b0;
    m_valid = 1'b0; m_pc = '0; m_instr = 32'h00000013; m_dec = 0; m_stall = 0; m_bub = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_stall();
    test_flush();
    test_decode();
    test_random();
`ifdef IDU_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
